// File: rtl/hbridge_multi_apb_if.sv
`default_nettype none
// ============================================================================
//  Module   : hbridge_multi_apb_if
//  Brief    : APB3 slave-side bus bundle for the multi-channel H-bridge block.
//  Revision : 1.0 - initial release
// ============================================================================
interface hbridge_multi_apb_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/hbridge_multi_apb.sv
`default_nettype none
// ============================================================================
//  Module   : hbridge_multi_apb
//  Brief    : APB3 slave driving NUM_MOTORS H-bridge channels from one shared
//             PWM timebase, with direction control, brake, safe reversal
//             (drain to zero duty first) and slew-limited duty ramping.
//  Options  : HBRIDGE_RAMP_EN - defined: duty ramps by RAMP_STEP per period;
//             undefined: applied duty jumps to target at the next boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module hbridge_multi_apb #(
    parameter int NUM_MOTORS = 2,
    parameter int PWM_PERIOD = 200000,
    parameter int RAMP_STEP  = 2000
) (
    input  wire logic                    PCLK,
    input  wire logic                    PRESERN,
    hbridge_multi_apb_if.slave           apb,
    output logic [NUM_MOTORS-1:0]        motor_pwm,
    output logic [2*NUM_MOTORS-1:0]      motor_ctrl
);

    // Duty values range 0..PWM_PERIOD inclusive.
    localparam int              DW        = $clog2(PWM_PERIOD + 1);
    localparam logic [DW-1:0]   c_PERIOD  = DW'(PWM_PERIOD);
    localparam logic [DW-1:0]   c_LAST    = DW'(PWM_PERIOD - 1);

`ifdef HBRIDGE_RAMP_EN
    localparam int c_STEP_REQ = RAMP_STEP;
`else
    // A step at least as large as the full duty range reaches any target in
    // a single boundary, which turns the ramp into a jump.
    localparam int c_STEP_REQ = (RAMP_STEP > PWM_PERIOD) ? RAMP_STEP : PWM_PERIOD;
`endif
    localparam int            c_STEP_I = (c_STEP_REQ > PWM_PERIOD) ? PWM_PERIOD : c_STEP_REQ;
    localparam logic [DW-1:0] c_STEP   = DW'(c_STEP_I);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Shared timebase
    // ------------------------------------------------------------------
    logic [DW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == c_LAST);

    // Free-running period counter; the wrap edge is the period boundary.
    always_ff @(posedge PCLK) begin
        if (!PRESERN)  cnt_q <= '0;
        else if (wrap) cnt_q <= '0;
        else           cnt_q <= cnt_q + DW'(1);
    end

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic [3:0]  a_ch;
    logic [1:0]  a_reg;
    logic        a_glob;
    logic        a_chok;
    logic        a_err;
    logic        acc;
    logic        wr_ok;
    logic [DW-1:0] duty_wv;
    logic [31:0] rd_word [NUM_MOTORS];

    assign a_ch   = apb.PADDR[7:4];
    assign a_reg  = apb.PADDR[3:2];
    assign a_glob = (a_ch == 4'hF);
    assign a_chok = (a_ch < 4'(NUM_MOTORS));
    // Global space has one read-only register; channel CUR/STAT are read-only.
    assign a_err  = a_glob ? ((a_reg != 2'd0) || apb.PWRITE)
                           : (!a_chok || (apb.PWRITE && a_reg[1]));
    assign acc    = apb.PSEL && apb.PENABLE;
    assign wr_ok  = acc && apb.PWRITE && !a_err;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = acc && a_err;

    // Oversized duty requests saturate at a full-on period.
    assign duty_wv = ({1'b0, apb.PWDATA[23:0]} > 25'(PWM_PERIOD)) ? c_PERIOD
                                                                   : DW'(apb.PWDATA[23:0]);

    logic w_unused;
    assign w_unused = ^{apb.PADDR[31:8], apb.PADDR[1:0], apb.PWDATA[31:24]};

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [1:0]    dir_q, dir_d;
        logic [1:0]    pend_q, pend_d;
        logic [1:0]    ctrl_q;
        logic [1:0]    mctrl_q, mctrl_d;
        logic [DW-1:0] duty_q;
        logic [DW-1:0] cur_q, cur_d;
        logic [DW-1:0] tgt;
        logic [DW-1:0] stepped;
        logic          pwm_q;
        logic          drain_done;
        logic          sel, ctrl_wr, duty_wr;
        logic [1:0]    wv;

        assign sel     = (a_ch == 4'(g));
        assign ctrl_wr = wr_ok && sel && (a_reg == 2'd0);
        assign duty_wr = wr_ok && sel && (a_reg == 2'd1);
        assign wv      = apb.PWDATA[1:0];
        assign tgt     = (state_q == ST_DRAIN) ? '0 : duty_q;

        // Applied duty one boundary later: move toward target by at most c_STEP.
        always_comb begin
            if (cur_q < tgt) stepped = ((tgt - cur_q) > c_STEP) ? (cur_q + c_STEP) : tgt;
            else             stepped = ((cur_q - tgt) > c_STEP) ? (cur_q - c_STEP) : tgt;
        end

`ifdef HBRIDGE_RAMP_EN
        assign drain_done = (stepped == '0);
`else
        // Without ramping the first boundary zeroes the duty; the direction
        // change waits one more full period so the bridge sees a dead period.
        logic drained_q, drained_d;
        assign drain_done = drained_q;

        // Marks that one boundary has already been spent draining.
        always_ff @(posedge PCLK) begin
            if (!PRESERN) drained_q <= 1'b0;
            else          drained_q <= drained_d;
        end

        // Cleared on every entry to DRAIN, set at its first boundary.
        always_comb begin
            drained_d = drained_q;
            if (state_q == ST_DRAIN && wrap) drained_d = 1'b1;
            if (state_q != ST_DRAIN)         drained_d = 1'b0;
        end
`endif

        // Channel FSM next state: boundary ramping first, CTRL writes override.
        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            pend_d  = pend_q;
            cur_d   = cur_q;
            case (state_q)
                ST_RUN: begin
                    if (wrap) cur_d = stepped;
                end
                ST_DRAIN: begin
                    if (wrap) begin
                        cur_d = stepped;
                        if (drain_done) begin
                            if (pend_q == 2'b00) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_RUN;
                                dir_d   = pend_q;
                            end
                        end
                    end
                end
                default: cur_d = '0;
            endcase

            if (ctrl_wr) begin
                if (wv == 2'b11) begin
                    state_d = ST_BRAKE;
                    cur_d   = '0;
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (wv != dir_q) begin
                                state_d = ST_DRAIN;
                                pend_d  = wv;
                            end
                        end
                        ST_DRAIN: begin
                            state_d = ST_DRAIN;
                            pend_d  = wv;
                        end
                        default: begin
                            if (wv == 2'b00) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_RUN;
                                dir_d   = wv;
                            end
                        end
                    endcase
                end
            end

            case (state_d)
                ST_RUN, ST_DRAIN: mctrl_d = dir_d;
                ST_BRAKE:         mctrl_d = 2'b11;
                default:          mctrl_d = 2'b00;
            endcase
        end

        // Channel registers; PWM only while RUN both before and after the edge.
        always_ff @(posedge PCLK) begin
            if (!PRESERN) begin
                state_q <= ST_IDLE;
                dir_q   <= '0;
                pend_q  <= '0;
                ctrl_q  <= '0;
                duty_q  <= '0;
                cur_q   <= '0;
                mctrl_q <= '0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                pend_q  <= pend_d;
                cur_q   <= cur_d;
                mctrl_q <= mctrl_d;
                pwm_q   <= (state_d == ST_RUN) && (state_q == ST_RUN) && (cnt_q < cur_q);
                if (ctrl_wr) ctrl_q <= wv;
                if (duty_wr) duty_q <= duty_wv;
            end
        end

        // Register read view for this channel.
        always_comb begin
            case (a_reg)
                2'd0:    rd_word[g] = {30'd0, ctrl_q};
                2'd1:    rd_word[g] = {{(32-DW){1'b0}}, duty_q};
                2'd2:    rd_word[g] = {{(32-DW){1'b0}}, cur_q};
                default: rd_word[g] = {30'd0, (cur_q == tgt), (state_q == ST_DRAIN)};
            endcase
        end

        assign motor_pwm[g]           = pwm_q;
        assign motor_ctrl[2*g+1:2*g]  = mctrl_q;
    end : g_ch

    // Read data mux; zero outside a selected, error-free access.
    always_comb begin
        apb.PRDATA = '0;
        if (apb.PSEL && !a_err) begin
            if (a_glob) begin
                apb.PRDATA = {24'h00048B, 4'h0, 4'(NUM_MOTORS)};
            end else begin
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    if (a_ch == 4'(i)) apb.PRDATA = rd_word[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hbridge_multi_apb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hbridge_multi_apb
//  Brief    : Directed self-checking bench for hbridge_multi_apb
//             (NUM_MOTORS=3, PWM_PERIOD=100, RAMP_STEP=10). Expected values
//             follow HBRIDGE_RAMP_EN when it is defined for the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hbridge_multi_apb;

    logic       PCLK = 1'b0;
    logic       PRESERN = 1'b0;
    logic [2:0] motor_pwm;
    logic [5:0] motor_ctrl;

    int checks = 0;
    int errors = 0;
    int tb_cnt = 0;

    hbridge_multi_apb_if apb_if ();

    hbridge_multi_apb #(
        .NUM_MOTORS (3),
        .PWM_PERIOD (100),
        .RAMP_STEP  (10)
    ) dut (
        .PCLK       (PCLK),
        .PRESERN    (PRESERN),
        .apb        (apb_if),
        .motor_pwm  (motor_pwm),
        .motor_ctrl (motor_ctrl)
    );

    always #5 PCLK = ~PCLK;

    // Reference period counter (0..99), used only to find boundaries.
    always @(posedge PCLK) begin
        if (!PRESERN)         tb_cnt <= 0;
        else if (tb_cnt == 99) tb_cnt <= 0;
        else                  tb_cnt <= tb_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        @(posedge PCLK); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = wr;
        apb_if.PADDR = addr; apb_if.PWDATA = wdata;
        @(posedge PCLK); #1;
        apb_if.PENABLE = 1'b1;
        #2;
        rdata = apb_if.PRDATA;
        err   = apb_if.PSLVERR;
        @(posedge PCLK); #1;
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    endtask

    // Returns 1 cycle after the edge on which the period wrapped.
    task automatic wait_bnd();
        forever begin
            @(posedge PCLK); #1;
            if (tb_cnt == 0) break;
        end
    endtask

    task automatic count_pwm(input int ch, output int n);
        n = 0;
        repeat (100) begin
            @(posedge PCLK); #1;
            n += int'(motor_pwm[ch]);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          n;

        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
        apb_if.PADDR = '0;  apb_if.PWDATA = '0;
        repeat (4) @(posedge PCLK);
        #1;
        check("rst_ctrl",   32'(motor_ctrl), 0);
        check("rst_pwm",    32'(motor_pwm), 0);
        check("rst_slverr", 32'(apb_if.PSLVERR), 0);
        check("idle_prdata", apb_if.PRDATA, 0);
        check("pready", 32'(apb_if.PREADY), 1);
        PRESERN = 1'b1;

        // Forward ramp on channel 0
        xfer(1, 32'h04, 35, d, e);   check("duty0_wr_err", 32'(e), 0);
        xfer(0, 32'h04, 0, d, e);    check("duty0_rd", d, 35);
        xfer(1, 32'h00, 1, d, e);
`ifdef HBRIDGE_RAMP_EN
        for (int k = 1; k <= 4; k++) begin
            wait_bnd();
            xfer(0, 32'h08, 0, d, e);
            check("cur0_up", d, (k < 4) ? 32'(k * 10) : 32'd35);
        end
`else
        wait_bnd();
        xfer(0, 32'h08, 0, d, e);    check("cur0_jump", d, 35);
`endif
        xfer(0, 32'h0C, 0, d, e);    check("stat0_at_tgt", d, 2);
        count_pwm(0, n);             check("pwm0_hi_count", 32'(n), 35);
        check("ctrl0_fwd", 32'(motor_ctrl[1:0]), 1);

        // Reversal: drain, then drive the new direction
        xfer(1, 32'h00, 2, d, e);
        check("pwm0_drain", 32'(motor_pwm[0]), 0);
        xfer(0, 32'h0C, 0, d, e);    check("stat0_drain", d, 1);
`ifdef HBRIDGE_RAMP_EN
        for (int k = 1; k <= 3; k++) begin
            wait_bnd();
            xfer(0, 32'h08, 0, d, e);
            check("cur0_down", d, 32'(35 - 10 * k));
            check("ctrl0_hold", 32'(motor_ctrl[1:0]), 1);
        end
        wait_bnd();
`else
        wait_bnd();
        xfer(0, 32'h08, 0, d, e);    check("cur0_down", d, 0);
        check("ctrl0_hold", 32'(motor_ctrl[1:0]), 1);
        xfer(0, 32'h0C, 0, d, e);    check("stat0_drain0", d, 3);
        wait_bnd();
`endif
        check("ctrl0_rev", 32'(motor_ctrl[1:0]), 2);
        xfer(0, 32'h08, 0, d, e);    check("cur0_zero", d, 0);
        xfer(0, 32'h0C, 0, d, e);    check("stat0_run", d, 0);
        wait_bnd();
        xfer(0, 32'h08, 0, d, e);
`ifdef HBRIDGE_RAMP_EN
        check("cur0_rev_up", d, 10);
`else
        check("cur0_rev_up", d, 35);
`endif

        // Channel 1 duty clamp and full-on PWM
        xfer(1, 32'h14, 500, d, e);
        xfer(0, 32'h14, 0, d, e);    check("duty1_clamp", d, 100);
        xfer(1, 32'h10, 1, d, e);
`ifdef HBRIDGE_RAMP_EN
        repeat (10) wait_bnd();
`else
        wait_bnd();
`endif
        xfer(0, 32'h18, 0, d, e);    check("cur1_full", d, 100);
        count_pwm(1, n);             check("pwm1_const", 32'(n), 100);

        // Error responses
        xfer(1, 32'h30, 1, d, e);    check("wr_ch3_err", 32'(e), 1);
        xfer(0, 32'h30, 0, d, e);    check("rd_ch3_err", 32'(e), 1);
        check("rd_ch3_data", d, 0);
        xfer(1, 32'h18, 5, d, e);    check("wr_cur_err", 32'(e), 1);
        xfer(0, 32'h18, 0, d, e);    check("cur1_kept", d, 100);
        check("ctrl_all", 32'(motor_ctrl), 32'h06);
        xfer(0, 32'hF0, 0, d, e);    check("glob_data", d, 32'h00048B03);
        check("glob_err", 32'(e), 0);
        xfer(0, 32'hF4, 0, d, e);    check("glob4_err", 32'(e), 1);
        xfer(1, 32'hF0, 7, d, e);    check("glob_wr_err", 32'(e), 1);

        // Brake mid-ramp
        xfer(1, 32'h04, 80, d, e);
        wait_bnd();
        xfer(0, 32'h08, 0, d, e);
`ifdef HBRIDGE_RAMP_EN
        check("cur0_mid", d, 45);
`else
        check("cur0_mid", d, 80);
`endif
        xfer(1, 32'h00, 3, d, e);
        check("brake_ctrl", 32'(motor_ctrl[1:0]), 3);
        check("brake_pwm", 32'(motor_pwm[0]), 0);
        xfer(0, 32'h08, 0, d, e);    check("brake_cur", d, 0);
        count_pwm(0, n);             check("brake_pwm_cnt", 32'(n), 0);
        xfer(1, 32'h00, 0, d, e);
        check("coast_ctrl", 32'(motor_ctrl[1:0]), 0);

        // Restart from IDLE
        xfer(1, 32'h04, 70, d, e);
        xfer(1, 32'h00, 1, d, e);
        wait_bnd();
        xfer(0, 32'h08, 0, d, e);
`ifdef HBRIDGE_RAMP_EN
        check("cur0_restart", d, 10);
`else
        check("cur0_restart", d, 70);
`endif

        // Reset mid-period with channel 1 full-on
        repeat (30) @(posedge PCLK);
        #1;
        check("pre_rst_pwm1", 32'(motor_pwm[1]), 1);
        PRESERN = 1'b0;
        @(posedge PCLK); #1;
        check("rst_run_pwm",  32'(motor_pwm), 0);
        check("rst_run_ctrl", 32'(motor_ctrl), 0);
        check("rst_run_err",  32'(apb_if.PSLVERR), 0);
        @(posedge PCLK); #1;
        PRESERN = 1'b1;
        xfer(0, 32'h18, 0, d, e);    check("rst_cur1", d, 0);
        xfer(0, 32'h14, 0, d, e);    check("rst_duty1", d, 0);
        xfer(0, 32'h10, 0, d, e);    check("rst_ctrl1", d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hbridge_multi_apb.md
# hbridge_multi_apb

Parametrised APB3 slave driving up to eight H-bridge channels from one shared PWM timebase, each with direction control, brake, and slew-limited duty ramping. It replaces the fixed two-motor H-bridge controller on CoreAPB3 slot 0 and is clocked by the MSS fabric clock and reset by the MSS-to-fabric reset. Direction reversals are made safe in hardware: the channel drains to zero duty before the new direction is driven.

## Interface
- NUM_MOTORS, 2, number of channels, 1..8
- PWM_PERIOD, 200000, PCLK cycles per PWM period, 2..2^24
- RAMP_STEP, 2000, maximum change of applied duty per PWM period, ≥1
- PCLK  in  1  fabric clock; all logic on rising edge
- PRESERN  in  1  reset, synchronous, active-low
- PSEL, PENABLE, PWRITE  in  1 each  APB3 controls
- PADDR  in  32  byte address; only [7:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1; zero wait states
- PSLVERR  out  1  access error
- motor_pwm  out  NUM_MOTORS  per-channel PWM
- motor_ctrl  out  2*NUM_MOTORS  channel n drives bits [2n+1:2n]

## Operation
- Address map: PADDR[7:4] selects channel n; 0xF selects global space. PADDR[3:2] selects the register.
- Channel registers:
  - 0 CTRL (RW, [1:0]): 00 coast, 01 forward, 10 reverse, 11 brake.
  - 1 DUTY (RW, [23:0]): target duty. Writes above PWM_PERIOD clamp to PWM_PERIOD.
  - 2 CUR (RO): applied duty.
  - 3 STAT (RO): [0] draining, [1] at target.
- Global register 0xF0 (RO): [3:0] NUM_MOTORS, [31:8] 0x48B.
- PSLVERR=1, and the write is ignored, for: writes to RO registers; channel n ≥ NUM_MOTORS; global offsets other than 0. Erroring reads return 0.
- Timebase: counter cnt runs 0..PWM_PERIOD-1 and wraps. A wrap is a period boundary.
- PWM output: motor_pwm[n] = registered (cnt < cur[n]) while the channel is in RUN with CTRL 01 or 10; otherwise 0. cur=PWM_PERIOD gives constant 1.
- Per-channel FSM, reset state IDLE:
  - IDLE: motor_ctrl=00, cur=0. A CTRL write of 01/10 stores the direction and goes to RUN.
  - RUN:
    - At each boundary, cur moves toward DUTY by min(RAMP_STEP, |DUTY−cur|).
    - A CTRL write with the opposite direction, or with 00, latches the pending value and goes to DRAIN.
  - DRAIN:
    - Target is forced to 0; cur ramps down at boundaries and motor_ctrl keeps the old direction.
    - When cur reaches 0 at a boundary, apply the pending CTRL (00 goes to IDLE; 01/10 goes to RUN with the new direction).
    - A further CTRL write while in DRAIN replaces the pending value.
  - BRAKE: entered from any state on a CTRL write of 11, taking effect on the next edge. motor_ctrl=11, cur=0, pwm=0. A write of 00/01/10 leaves via the IDLE rules.
- A write of the same direction while in RUN is a no-op.
- A DUTY write in any state updates the target only; the applied duty follows at later boundaries.

## Timing
- APB writes commit on the PCLK edge where PSEL&PENABLE&PWRITE.
- PRDATA is combinational in the access phase and 0 when PSEL=0.
- CTRL-to-FSM latency is 1 cycle. Duty changes appear only at period boundaries, never mid-period.
- motor_pwm lags cnt by 1 cycle.
- A write and a boundary on the same edge: the boundary uses the old target; the new target applies from the next boundary.
- Reset while running: cnt=0, all registers and cur=0, FSMs to IDLE, motor_pwm=0, motor_ctrl=0, PSLVERR=0.

## Configuration
- HBRIDGE_RAMP_EN:
  - Defined: ramping as described.
  - Undefined: RAMP_STEP is ignored and cur jumps to the target at the next boundary. DRAIN still lasts at least one full period with pwm=0 before the direction change.

## Test plan
All scenarios use PWM_PERIOD=100, RAMP_STEP=10, NUM_MOTORS=3, with the macro defined unless stated.
- Write DUTY0=35, CTRL0=01:
  - CUR0 reads 10, 20, 30, 35 after boundaries 1–4, then STAT0[1]=1.
  - motor_pwm[0] is high for 35 cycles per period.
  - motor_ctrl[1:0] stays 01.
- At CUR0=30 forward, write CTRL0=10:
  - STAT0[0]=1 and motor_ctrl stays 01 while CUR ramps 20, 10, 0.
  - At the boundary where CUR reaches 0, motor_ctrl becomes 10, then CUR ramps back up toward 35.
- Write DUTY1=500 → reads back 100. With CTRL1=01 and the ramp complete, motor_pwm[1] is constant 1.
- Write to channel 3, write to a CUR register, and read 0xF0:
  - The two writes give PSLVERR=1 with no state change.
  - The read returns 0x00048B03.
- Brake mid-ramp: CTRL0=11 → next cycle motor_ctrl[1:0]=11, pwm=0, CUR0=0.
- With the macro undefined, DUTY0=70, CTRL0=01 → CUR0=70 after the first boundary. Deassert PRESERN mid-period → all outputs 0 on the next edge.
